// File: rtl/arb_mux2_16bit_if.sv
// arb_mux2_16bit_if: requester/consumer bus for the two-way arbitrating 16-bit mux
interface arb_mux2_16bit_if #(parameter int WIDTH = 16);
  logic             req0;
  logic [WIDTH-1:0] hyrja0;
  logic             req1;
  logic [WIDTH-1:0] hyrja1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] dalja;
  logic             valid;
  logic             ready;
  logic             sel;
  modport master (output req0, hyrja0, req1, hyrja1, ready, input ack0, ack1, dalja, valid, sel);
  modport slave (input req0, hyrja0, req1, hyrja1, ready, output ack0, ack1, dalja, valid, sel);
endinterface

// File: rtl/arb_mux2_16bit.sv
// arb_mux2_16bit: round-robin (or fixed priority with ARB_FIXED_PRIO_EN) arbiter feeding a registered 16-bit 2:1 mux
module arb_mux2_16bit #(parameter int WIDTH = 16) (
  input logic           i_clk,
  input logic           i_rst,
  arb_mux2_16bit_if.slave io_bus
);
  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_dalja;
  logic             r_sel;
  logic             w_load;
  logic             w_g0;
  logic             w_g1;
  assign w_load = (r_state == IDLE) || io_bus.ready;
`ifdef ARB_FIXED_PRIO_EN
  assign w_g1 = io_bus.req1 && !io_bus.req0;
`else
  logic r_last;
  assign w_g1 = io_bus.req1 && (!io_bus.req0 || !r_last);
  always_ff @(posedge i_clk)
    if (i_rst) r_last <= 1'b1;
    else if (w_load && (w_g0 || w_g1)) r_last <= w_g1;
`endif
  assign w_g0 = io_bus.req0 && !w_g1;
  assign io_bus.ack0 = !i_rst && w_load && w_g0;
  assign io_bus.ack1 = !i_rst && w_load && w_g1;
  assign io_bus.dalja = r_dalja;
  assign io_bus.sel = r_sel;
  assign io_bus.valid = r_state != IDLE;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_state <= IDLE;
      r_dalja <= '0;
      r_sel <= 1'b0;
    end else if (w_load) begin
      r_state <= w_g1 ? HOLD1 : w_g0 ? HOLD0 : IDLE;
      if (w_g0 || w_g1) begin
        r_dalja <= w_g1 ? io_bus.hyrja1 : io_bus.hyrja0;
        r_sel <= w_g1;
      end
    end
endmodule

// File: tb/tb_arb_mux2_16bit.sv
// tb_arb_mux2_16bit: directed self-checking bench for arb_mux2_16bit
module tb_arb_mux2_16bit;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic m_hold = 1'b0;
  logic [15:0] m_d = '0;
  logic m_sel = 1'b0;
  arb_mux2_16bit_if bus();
  arb_mux2_16bit dut (.i_clk(clk), .i_rst(rst), .io_bus(bus.slave));
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    checks++;
    assert ((bus.ack0 & bus.ack1) !== 1'b1) else begin
      errors++;
      $error("FAIL ack_excl observed %b%b expected not both", bus.ack0, bus.ack1);
    end
    if (m_hold) begin
      checks++;
      assert (bus.dalja === m_d && bus.sel === m_sel) else begin
        errors++;
        $error("FAIL hold_stable observed %h/%b expected %h/%b", bus.dalja, bus.sel, m_d, m_sel);
      end
    end
    m_hold = !rst && bus.valid === 1'b1 && !bus.ready;
    m_d = bus.dalja;
    m_sel = bus.sel;
  end
  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.hyrja0 = '0;
    bus.hyrja1 = '0;
    bus.ready = 1'b0;
    cyc();
    bus.req0 = 1'b1;
    bus.hyrja0 = 16'h1234;
    #1;
    chk("ack0_in_reset", {15'd0, bus.ack0}, 16'd0);
    cyc();
    chk("rst_valid", {15'd0, bus.valid}, 16'd0);
    chk("rst_dalja", bus.dalja, 16'h0000);
    chk("rst_sel", {15'd0, bus.sel}, 16'd0);
    rst = 1'b0;
    bus.ready = 1'b1;
    #1;
    chk("first_ack0", {15'd0, bus.ack0}, 16'd1);
    chk("first_ack1", {15'd0, bus.ack1}, 16'd0);
    cyc();
    bus.req0 = 1'b0;
    #1;
    chk("first_valid", {15'd0, bus.valid}, 16'd1);
    chk("first_dalja", bus.dalja, 16'h1234);
    chk("first_sel", {15'd0, bus.sel}, 16'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.hyrja0 = 16'hAAAA;
    bus.hyrja1 = 16'h5555;
    bus.ready = 1'b1;
    #1;
    chk("tie_ack0", {15'd0, bus.ack0}, 16'd1);
    cyc();
    chk("tie_w1", bus.dalja, 16'hAAAA);
`ifdef ARB_FIXED_PRIO_EN
    cyc();
    chk("tie_w2", bus.dalja, 16'hAAAA);
    chk("tie_s2", {15'd0, bus.sel}, 16'd0);
    cyc();
    chk("tie_w3", bus.dalja, 16'hAAAA);
`else
    chk("tie_ack1", {15'd0, bus.ack1}, 16'd1);
    cyc();
    chk("tie_w2", bus.dalja, 16'h5555);
    chk("tie_s2", {15'd0, bus.sel}, 16'd1);
    cyc();
    chk("tie_w3", bus.dalja, 16'hAAAA);
`endif
    bus.req1 = 1'b0;
    bus.hyrja0 = 16'h00FF;
    #1;
    chk("ff_ack0", {15'd0, bus.ack0}, 16'd1);
    cyc();
    bus.req0 = 1'b0;
    bus.req1 = 1'b1;
    bus.hyrja1 = 16'hBEEF;
    bus.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_dalja", bus.dalja, 16'h00FF);
      chk("stall_ack1", {15'd0, bus.ack1}, 16'd0);
      chk("stall_valid", {15'd0, bus.valid}, 16'd1);
      cyc();
    end
    bus.ready = 1'b1;
    #1;
    chk("unstall_ack1", {15'd0, bus.ack1}, 16'd1);
    cyc();
    chk("unstall_dalja", bus.dalja, 16'hBEEF);
    for (int i = 1; i <= 4; i++) begin
      bus.hyrja1 = 16'h1111 * i[15:0];
      #1;
      chk("stream_ack1", {15'd0, bus.ack1}, 16'd1);
      cyc();
      chk("stream_dalja", bus.dalja, 16'h1111 * i[15:0]);
      chk("stream_sel", {15'd0, bus.sel}, 16'd1);
      chk("stream_valid", {15'd0, bus.valid}, 16'd1);
    end
    bus.ready = 1'b0;
    cyc();
    chk("pre_rst_dalja", bus.dalja, 16'h4444);
    rst = 1'b1;
    bus.req0 = 1'b1;
    #1;
    chk("rst_ack0", {15'd0, bus.ack0}, 16'd0);
    chk("rst_ack1", {15'd0, bus.ack1}, 16'd0);
    cyc();
    chk("rst2_valid", {15'd0, bus.valid}, 16'd0);
    chk("rst2_dalja", bus.dalja, 16'h0000);
    rst = 1'b0;
    bus.hyrja0 = 16'hAAAA;
    bus.hyrja1 = 16'h5555;
    #1;
    chk("post_rst_ack0", {15'd0, bus.ack0}, 16'd1);
    chk("post_rst_ack1", {15'd0, bus.ack1}, 16'd0);
    cyc();
    chk("post_rst_dalja", bus.dalja, 16'hAAAA);
    chk("post_rst_sel", {15'd0, bus.sel}, 16'd0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.ready = 1'b1;
    cyc();
    chk("drain_valid", {15'd0, bus.valid}, 16'd0);
    chk("drain_dalja", bus.dalja, 16'hAAAA);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
